// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, ALU opcodes, immediate-extension
// selects and the ID/EX slot payload used by alu_operand_stage.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREG    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned ALUOP_W = 5;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADDU = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_SUBU = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 5'd6;

    localparam logic IMM_EXT_ZERO = 1'b0;
    localparam logic IMM_EXT_SIGN = 1'b1;

    // ID/EX slot contents handed to the ALU
    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_AW-1:0]  rd;
        logic               we;
    } idex_t;

    // lui relies on zero mode; the ALU performs the 16-bit shift itself
    function automatic logic [XLEN-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic             mode);
        logic [XLEN-IMM_W-1:0] upper;
        upper = (mode == IMM_EXT_SIGN) ? {(XLEN-IMM_W){imm[IMM_W-1]}}
                                       : (XLEN-IMM_W)'(0);
        return {upper, imm};
    endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// 32x32 general register file: two combinational read ports, one write port.
// Register 0 reads as zero and ignores writes.
module regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [XLEN-1:0]   rd_data_a_c,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_b_c,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    // Next-state: single write port, register 0 guarded
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en && (wr_addr != REG_AW'(0))) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data_a_c = (rd_addr_a == REG_AW'(0)) ? XLEN'(0) : mem_q[rd_addr_a];
    assign rd_data_b_c = (rd_addr_b == REG_AW'(0)) ? XLEN'(0) : mem_q[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the ALU: register file, immediate extension and
// a single ID/EX slot with valid/ready, stall and flush. Define WB_BYPASS_EN to
// forward a same-edge writeback into the captured operands.
module alu_operand_stage
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REG_AW-1:0]  in_rs,
    input  logic [REG_AW-1:0]  in_rt,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic               in_imm_sel,
    input  logic               in_imm_sign,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic [REG_AW-1:0]  in_rd,
    input  logic               in_we,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_a,
    output logic [XLEN-1:0]    out_b,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_we,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [XLEN-1:0]    wb_data
);

    logic [XLEN-1:0] rd_a_c;
    logic [XLEN-1:0] rd_b_c;
    logic [XLEN-1:0] imm_ext_c;
    logic [XLEN-1:0] op_a_c;
    logic [XLEN-1:0] op_b_c;
    logic            capture_c;

    logic  valid_q, valid_d;
    idex_t slot_q, slot_d;

    regfile u_regfile (
        .clk         (clk),
        .rstn        (rstn),
        .rd_addr_a   (in_rs),
        .rd_data_a_c (rd_a_c),
        .rd_addr_b   (in_rt),
        .rd_data_b_c (rd_b_c),
        .wr_en       (wb_we),
        .wr_addr     (wb_addr),
        .wr_data     (wb_data)
    );

    assign imm_ext_c = ext_imm(in_imm, in_imm_sign);

`ifdef WB_BYPASS_EN
    logic wb_live_c;
    logic byp_a_c;
    logic byp_b_c;

    assign wb_live_c = wb_we && (wb_addr != REG_AW'(0));
    assign byp_a_c   = wb_live_c && (wb_addr == in_rs);
    assign byp_b_c   = wb_live_c && (wb_addr == in_rt);
    assign op_a_c    = byp_a_c ? wb_data : rd_a_c;
    assign op_b_c    = in_imm_sel ? imm_ext_c : (byp_b_c ? wb_data : rd_b_c);
`else
    // Same-edge writeback is not visible; the hazard unit inserts a bubble
    assign op_a_c    = rd_a_c;
    assign op_b_c    = in_imm_sel ? imm_ext_c : rd_b_c;
`endif

    assign in_ready  = !valid_q || out_ready;
    assign capture_c = in_valid && in_ready && !flush;

    // Slot next-state: flush beats capture, capture beats drain, else hold
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture_c) begin
            valid_d      = 1'b1;
            slot_d.a     = op_a_c;
            slot_d.b     = op_b_c;
            slot_d.aluop = in_aluop;
            slot_d.rd    = in_rd;
            slot_d.we    = in_we;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = slot_q.a;
    assign out_b     = slot_q.b;
    assign out_aluop = slot_q.aluop;
    assign out_rd    = slot_q.rd;
    assign out_we    = slot_q.we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed plan followed by random
// traffic, checked against a register-array reference model.
module tb_alu_operand_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs, in_rt, in_aluop, in_rd;
    logic [15:0] in_imm;
    logic        in_imm_sel, in_imm_sign, in_we, flush;
    logic        out_valid, out_ready, out_we;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_aluop, out_rd;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_imm_sel(in_imm_sel), .in_imm_sign(in_imm_sign),
        .in_aluop(in_aluop), .in_rd(in_rd), .in_we(in_we),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_aluop(out_aluop),
        .out_rd(out_rd), .out_we(out_we),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    typedef struct packed {
        logic        iv;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic        isel, isgn;
        logic [4:0]  op, rd;
        logic        we, fl, ordy, wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
    } stim_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_regs [32];
    logic        m_valid;
    idex_t       exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.ordy = 1'b1;
        return s;
    endfunction

    // Reference read: register 0 is zero, optional same-edge writeback forwarding
    function automatic logic [31:0] m_read(input logic [4:0] r, input stim_t s);
        if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (s.wbwe && s.wba == r) return s.wbd;
`endif
        return m_regs[r];
    endfunction

    function automatic logic [31:0] m_ext(input logic [15:0] imm, input logic sgn);
        logic [31:0] v = 32'(imm);
        if (sgn && imm[15]) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0;
        exp_q.delete();
    endfunction

    task automatic apply(input stim_t s);
        in_valid = s.iv; in_rs = s.rs; in_rt = s.rt; in_imm = s.imm;
        in_imm_sel = s.isel; in_imm_sign = s.isgn; in_aluop = s.op;
        in_rd = s.rd; in_we = s.we; flush = s.fl; out_ready = s.ordy;
        wb_we = s.wbwe; wb_addr = s.wba; wb_data = s.wbd;
    endtask

    // One clock: check slot occupancy and in_ready, then advance the model
    task automatic run(input stim_t s);
        logic  exp_rdy;
        idex_t e;
        @(posedge clk); #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        apply(s);
        #1;
        exp_rdy = !m_valid || s.ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (s.fl) begin
            if (m_valid) void'(exp_q.pop_front());
            m_valid = 1'b0;
        end else if (s.iv && exp_rdy) begin
            e.a     = m_read(s.rs, s);
            e.b     = s.isel ? m_ext(s.imm, s.isgn) : m_read(s.rt, s);
            e.aluop = s.op;
            e.rd    = s.rd;
            e.we    = s.we;
            exp_q.push_back(e);
            m_valid = 1'b1;
        end else if (s.ordy) begin
            m_valid = 1'b0;
        end
        if (s.wbwe && s.wba != 5'd0) m_regs[s.wba] = s.wbd;
    endtask

    // Monitor: the slot is consumed when valid meets ready without a flush
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: unexpected output a=0x%08h at %0t", out_a, $time);
            end else begin
                idex_t e;
                e = exp_q.pop_front();
                chk("out_a", out_a, e.a);
                chk("out_b", out_b, e.b);
                chk("out_aluop", 32'(out_aluop), 32'(e.aluop));
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                chk("out_we", 32'(out_we), 32'(e.we));
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_a"}, out_a, 32'd0);
        chk({tag, "_out_b"}, out_b, 32'd0);
        chk({tag, "_out_aluop"}, 32'(out_aluop), 32'd0);
        chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_out_we"}, 32'(out_we), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        stim_t s;
        apply(idle());
        m_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rstn = 1'b1;

        // Immediate extension and register reads
        s = idle(); s.wbwe = 1; s.wba = 5; s.wbd = 32'h7; run(s);
        s = idle(); s.iv = 1; s.rs = 5; s.isel = 1; s.imm = 16'hFFFE; s.isgn = 1; s.rd = 8; s.we = 1; run(s);
        s.isgn = 0; s.op = ALU_LUI; run(s);
        s = idle(); s.wbwe = 1; s.wba = 0; s.wbd = 32'h1234; run(s);
        s = idle(); s.iv = 1; s.rs = 0; s.rt = 0; run(s);

        // Same-edge capture and writeback
        s = idle(); s.iv = 1; s.rs = 9; s.rt = 9; s.op = ALU_ADDU;
        s.wbwe = 1; s.wba = 9; s.wbd = 32'hDEAD_BEEF; run(s);
        s = idle(); s.iv = 1; s.rs = 9; s.rt = 5; run(s);

        // Stall for three cycles with a queued instruction, then release
        s = idle(); s.iv = 1; s.rs = 5; s.rt = 9; s.op = ALU_SUBU; s.rd = 1; s.ordy = 0; run(s);
        s = idle(); s.iv = 1; s.rs = 9; s.isel = 1; s.imm = 16'h8001; s.isgn = 1; s.op = ALU_OR; s.rd = 2; s.we = 1; s.ordy = 0;
        repeat (3) run(s);
        s.ordy = 1; run(s);

        // Flush with a held slot and an incoming instruction; writeback still lands
        s = idle(); s.iv = 1; s.rs = 5; s.op = ALU_AND; s.rd = 4; s.ordy = 0; run(s);
        s = idle(); s.iv = 1; s.rs = 9; s.op = ALU_SLT; s.rd = 6; s.fl = 1; s.ordy = 0;
        s.wbwe = 1; s.wba = 3; s.wbd = 32'hA5A5_5A5A; run(s);
        s = idle(); s.iv = 1; s.rs = 3; s.rt = 3; s.rd = 7; run(s);
        run(idle());

        // Random traffic with frequent register-address collisions
        for (int i = 0; i < 400; i++) begin
            s.iv   = ($urandom_range(0, 3) != 0);
            s.rs   = 5'($urandom_range(0, 7));
            s.rt   = 5'($urandom_range(0, 7));
            s.imm  = 16'($urandom);
            s.isel = 1'($urandom);
            s.isgn = 1'($urandom);
            s.op   = 5'($urandom_range(0, 6));
            s.rd   = 5'($urandom);
            s.we   = 1'($urandom);
            s.fl   = ($urandom_range(0, 19) == 0);
            s.ordy = ($urandom_range(0, 3) != 0);
            s.wbwe = 1'($urandom);
            s.wba  = 5'($urandom_range(0, 7));
            s.wbd  = $urandom;
            run(s);
        end

        // Asynchronous reset in the middle of a stall
        for (int r = 1; r < 32; r++) begin
            s = idle(); s.wbwe = 1; s.wba = 5'(r); s.wbd = $urandom | 32'h1; run(s);
        end
        s = idle(); s.iv = 1; s.rs = 12; s.rt = 13; s.op = ALU_ADD; s.rd = 3; s.we = 1; s.ordy = 0; run(s);
        s.rs = 14; run(s);
        #1;
        apply(idle());
        rstn = 1'b0;
        #1;
        chk_zero_outputs("midstall_reset");
        m_reset();
        @(negedge clk); #1;
        rstn = 1'b1;

        // Every register reads zero after reset
        for (int r = 0; r < 32; r++) begin
            s = idle(); s.iv = 1; s.rs = 5'(r); s.rt = 5'(31 - r); s.rd = 5'(r); run(s);
        end
        run(idle());
        run(idle());
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of the ALU in the MIPS datapath. Holds the 32×32 general register file, reads two source registers and forms the second operand from a register or an extended 16-bit immediate. Registers operands plus ALU opcode and destination info into a single ID/EX pipeline slot with valid/ready handshake, stall and flush. Accepts the writeback port that updates the register file.

## Interface
- XLEN, 32, datapath width
- NREG, 32, number of general registers; register 0 is hardwired to zero
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_rs  in  5  source register for a
- in_rt  in  5  source register for b
- in_imm  in  16  immediate field
- in_imm_sel  in  1  1: b = extended immediate; 0: b = reg[in_rt]
- in_imm_sign  in  1  1: sign-extend immediate; 0: zero-extend
- in_aluop  in  5  ALU opcode, passed through
- in_rd  in  5  destination register
- in_we  in  1  instruction writes in_rd
- flush  in  1  kill the held slot and the incoming instruction
- out_valid  out  1  slot holds a valid instruction for the ALU
- out_ready  in  1  ALU/EX side consumes the slot this cycle
- out_a, out_b  out  32  ALU operands
- out_aluop  out  5  registered opcode
- out_rd  out  5  registered destination
- out_we  out  1  registered write enable
- wb_we  in  1  writeback enable
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback value

## Operation
- in_ready = !out_valid || out_ready (combinational, independent of in_valid).
- Capture: on the rising edge with in_valid && in_ready && !flush, load out_a = reg[in_rs] and out_b = operand b. Also load out_aluop, out_rd, out_we. Set out_valid = 1.
- No new capture and out_valid && out_ready: out_valid <= 0; data fields keep their old values.
- Stall (out_valid && !out_ready): all out_* hold. Held operands are not refreshed by later writebacks; the hazard unit handles this.
- Immediate: sign mode replicates bit 15 into bits 31:16; zero mode fills with 0. The ALU performs the lui shift, so lui uses zero mode.
- Register reads of address 0 return 0.
- Writeback: on the rising edge with wb_we && wb_addr != 0, reg[wb_addr] <= wb_data. Writes to register 0 are discarded.
- Flush: out_valid <= 0 on that edge, and the incoming instruction is dropped. Flush wins over capture and over stall. The register file still accepts writeback on that edge.
- out_rd and out_we pass through unchanged. out_we is meaningful only while out_valid = 1.

## Timing
- Reset (rstn low, asynchronous): every register = 0; out_valid = 0; out_a = out_b = 0; out_aluop = 0; out_rd = 0; out_we = 0. in_ready = 1 immediately after reset.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction/cycle while out_ready stays high.
- Writeback becomes visible to a capture on the following edge. Same-edge visibility depends on the configuration below.
- Reset asserted mid-stall discards the held slot. The first cycle after deassertion accepts new input.

## Configuration
- WB_BYPASS_EN defined: if a capture and a writeback occur on the same edge, wb_we = 1 and wb_addr != 0 matches in_rs (or in_rt with in_imm_sel = 0), the captured operand is wb_data.
- WB_BYPASS_EN undefined: on that same edge the captured operand is the pre-write register value. The upstream hazard unit then inserts a one-cycle bubble.

## Structure
- Shared package mips_pkg holds:
  - XLEN and register-address width (5)
  - ALU opcode constants: add 0, addu 1, subu 2, and 3, or 4, slt 5, lui 6
  - immediate-extension select constants
- Sub-module regfile contains:
  - 32×32 array with async-low reset
  - two combinational read ports
  - one write port with the register-0 guard
- alu_operand_stage adds the extension logic, the bypass, and the pipeline slot/handshake.

## Test plan
- Reset, then wb write reg[5] = 0x0000_0007. Capture rs = 5, imm_sel = 1, imm = 0xFFFE, sign = 1, aluop = 0 → next cycle out_valid = 1, out_a = 7, out_b = 0xFFFF_FFFE.
- Same capture with sign = 0 → out_b = 0x0000_FFFE. Write wb_addr = 0, data 0x1234, then read rs = 0 → out_a = 0.
- Capture rs = 9 on the same edge as a wb write of reg[9] = 0xDEAD_BEEF → out_a = 0xDEAD_BEEF with WB_BYPASS_EN defined; the old value (0) without it.
- Stall: out_ready = 0 for 3 cycles with in_valid high → in_ready = 0 throughout and outputs stable. out_ready = 1 → the queued instruction is captured on that edge.
- Flush asserted with a valid held slot and in_valid = 1 → out_valid = 0 next cycle, neither instruction appears, and a concurrent wb write still lands.
- rstn pulsed low asynchronously mid-stall → out_valid and all outputs go to 0 immediately, and every register reads 0 afterwards.
